// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between pc_sequencer (master) and instruction memory (slave).
// imem_req is held high while the sequencer fetches. The fetch completes on the rising
// edge where imem_ready is also high. imem_addr stays stable for the whole request.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer that owns the program counter and the retired-instruction count.
// Optional macro PC_MISALIGN_TRAP_EN adds a trap on a misaligned next PC, with misalign/epc outputs.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              reset,
  pc_sequencer_if.master    imem,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [31:0]       jr_target,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4,
  output logic              instr_valid,
  output logic [31:0]       retired,
  output logic              halted,
`ifdef PC_MISALIGN_TRAP_EN
  output logic              misalign,
  output logic [31:0]       epc,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] retired_q, retired_nxt;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        exec_exit;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misaligned;
  logic        misalign_q;
  logic [31:0] epc_q;
`endif

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Redirect priority: jr, then jump, then taken branch, then fall-through.
  always_comb begin
    target = pc_plus4;
    if (jr)
      target = jr_target;
    else if (jump)
      target = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      target = pc_plus4 + branch_off;
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = (target[1:0] != 2'b00);
  assign next_pc    = misaligned ? TRAP_VECTOR : target;
`else
  assign next_pc = {target[31:2], 2'b00};
  logic unused_ok;
  assign unused_ok = ^{TRAP_VECTOR, target[1:0]};
`endif

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    retired_nxt = retired_q;
    exec_exit   = 1'b0;
    case (state)
      FETCH: begin
        if (imem.imem_ready)
          state_nxt = EXEC;
      end
      EXEC: begin
        if (halt) begin
          state_nxt   = HALTED;
          retired_nxt = retired_q + 32'd1;
        end else if (!stall) begin
          state_nxt   = FETCH;
          pc_nxt      = next_pc;
          retired_nxt = retired_q + 32'd1;
          exec_exit   = 1'b1;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      retired_q <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
      epc_q      <= 32'd0;
`endif
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      retired_q <= retired_nxt;
`ifdef PC_MISALIGN_TRAP_EN
      // Set only on the EXEC exit edge, so it is high for the single following FETCH cycle.
      misalign_q <= exec_exit && misaligned;
      if (exec_exit && misaligned)
        epc_q <= target;
`endif
    end
  end

  // Handshake and valid outputs are forced low for as long as reset is held.
  assign imem.imem_req  = reset && (state == FETCH);
  assign imem.imem_addr = pc;
  assign pc_out         = pc;
  assign instr_valid    = reset && (state == EXEC);
  assign halted         = reset && (state == HALTED);
  assign retired        = retired_q;
  assign dbg_state      = state;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
  assign epc      = epc_q;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/advance controller wrapped around the program counter register. It sequences each instruction through a fetch handshake with instruction memory and an execute phase. In the execute phase it selects the next PC from sequential, branch, jump and register-jump sources, and applies stall and halt. It sits between the PC, the instruction memory port and the control/decode unit, and replaces the free-running PC update in the CPU top level.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h8000_0180, redirect target for misaligned next-PC (optional feature only)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk edge
imem_ready  input  1  instruction memory has data for imem_addr this cycle
stall  input  1  hold current instruction in execute phase
halt  input  1  decoded halt/syscall-stop; stops sequencing
branch_taken  input  1  conditional branch resolved taken
branch_imm  input  16  raw branch immediate (word offset)
jump  input  1  J/JAL
jump_index  input  26  J-type target field
jr  input  1  JR/JALR
jr_target  input  32  register value for JR
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (= pc_out)
pc_out  output  32  current PC
pc_plus4  output  32  pc_out + 4, for link writes
instr_valid  output  1  fetched instruction is valid/executing
retired  output  32  count of completed instructions
halted  output  1  sequencer stopped

Behaviour:
- Reset (reset==0 at a rising edge), in any state, mid-fetch included: pc=RESET_VECTOR, state=FETCH, retired=0, halted=0. While reset==0: imem_req=0, instr_valid=0. An imem_ready in the same cycle is ignored.
- FSM states: FETCH, EXEC, HALTED.
- FETCH: imem_req=1, instr_valid=0. imem_ready==1 -> EXEC next cycle. Otherwise stay in FETCH with no timeout.
- EXEC: imem_req=0, instr_valid=1. Control inputs are sampled only in EXEC.
  - halt==1 -> HALTED; pc unchanged; retired+1. halt has priority over stall and all redirects.
  - Else stall==1 -> stay in EXEC; pc and retired unchanged.
  - Else pc <= next_pc, retired+1, -> FETCH.
- HALTED: imem_req=0, instr_valid=0, halted=1. Only reset exits this state.
- imem_ready is ignored in EXEC and HALTED.
- next_pc priority: jr > jump > branch_taken > sequential.
  - sequential = pc+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
  - branch = pc_plus4 + (sign_extend(branch_imm) << 2), 32-bit wrap.
  - jump = {pc_plus4[31:28], jump_index, 2'b00}.
  - jr = jr_target.
- Without the optional feature, next_pc[1:0] is forced to 2'b00.
- retired is 32-bit and wraps from 0xFFFF_FFFF to 0.
- Minimum throughput is 2 cycles per instruction: imem_ready in the FETCH cycle, then one EXEC cycle.
- pc_plus4 is combinational from pc_out.

Optional Feature:
Macro PC_MISALIGN_TRAP_EN.
- Defined: adds outputs misalign (1-bit) and epc (32-bit).
  - If the EXEC-exit next_pc[1:0]!=0 (only possible via jr), pc <= TRAP_VECTOR instead.
  - misalign pulses high for exactly one cycle (the following FETCH cycle).
  - epc <= the offending address.
  - retired still increments.
  - epc resets to 0 and misalign to 0.
- Undefined: ports absent; low bits forced to zero as above.

Test Plan:
- Reset then imem_ready held 1, no redirects -> pc_out 0,4,8 on successive EXEC phases; retired=3 after 3 instructions; imem_req alternates 1/0.
- pc=0x100, branch_taken=1, branch_imm=16'hFFFE -> next pc=0x0FC. With jr=1, jr_target=0x400 and jump=1 in the same cycle -> pc=0x400 (jr wins).
- pc=0x1000_0040, jump=1, jump_index=26'h000_0010 -> pc=0x1000_0040.
- stall high 3 cycles in EXEC at pc=0x8 -> pc, retired frozen, instr_valid=1 throughout; pc=0xC one cycle after stall drops.
- Hold imem_ready low 5 cycles in FETCH, then assert reset=0 for one edge -> pc=RESET_VECTOR, imem_req=0 during reset, FETCH restarts cleanly. Assert halt in EXEC -> halted=1, imem_req stays 0 despite imem_ready pulses.
- PC_MISALIGN_TRAP_EN defined: jr=1, jr_target=0x202 -> pc=0x8000_0180, epc=0x202, misalign high exactly 1 cycle. Macro undefined: same stimulus -> pc=0x200.
